video_frame_reader: RTL and testbench
=====================================

VIDEO_FRAME_READER -- requirements
Module: video_frame_reader

Interface
REQ-001 Parameter BASE_ADDR, default 21'h000000: SDRAM word address of the first burst of the frame.
REQ-002 Parameter FRAME_WORDS, default 153600: 32-bit words per frame; must be a multiple of 8.
REQ-003 Parameter ADDR_STEP, default 8: address increment per burst.
REQ-004 Parameter TIMEOUT, default 64: cycles without a data beat before the block declares an error.
REQ-005 clk  in  1  block clock; one clock only; all logic on posedge clk.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 init_done  in  1  SDRAM controller initialised; start_frame is ignored while low.
REQ-008 start_frame  in  1  single-cycle request to read one full frame.
REQ-009 cmd  out  1  memory command; always 0 (read).
REQ-010 cmd_en  out  1  one-cycle command strobe.
REQ-011 addr  out  21  burst address, valid while cmd_en=1.
REQ-012 rd_data  in  32  read beat data, low pixel in [15:0], high pixel in [31:16].
REQ-013 rd_data_valid  in  1  rd_data qualifier.
REQ-014 queue_wr_en  out  1  write strobe to the output pixel queue.
REQ-015 queue_data  out  17  queue entry; 17'h10000 marks start of frame, else {1'b0, pixel}.
REQ-016 queue_afull  in  1  queue has fewer than 17 free entries.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 error  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, SOF, REQ, WAIT, RECV, DRAIN.
REQ-020 IDLE -> SOF: start_frame=1 and init_done=1 in the same cycle. The burst index resets to 0.
REQ-021 SOF: for one cycle, queue_wr_en=1 and queue_data=17'h10000; then go to REQ. Ignores queue_afull.
REQ-022 REQ: wait while queue_afull=1. When queue_afull=0, assert cmd_en=1, cmd=0, addr=BASE_ADDR+burst_idx*ADDR_STEP for exactly one cycle; then go to WAIT.
REQ-023 WAIT -> RECV on the first rd_data_valid=1. That beat is captured as word 0.
REQ-024 RECV: capture one word per rd_data_valid=1 cycle into an 8x32 buffer. Gaps in valid are tolerated. After the 8th word, go to DRAIN.
REQ-025 DRAIN: write 16 entries, one per cycle, with queue_wr_en=1 on consecutive cycles.
  - Order: word0[15:0], word0[31:16], word1[15:0], and so on.
REQ-026 After DRAIN:
  - if (burst_idx+1)*8 < FRAME_WORDS, increment burst_idx and go to REQ;
  - otherwise go to IDLE.
REQ-027 Timeout counter:
  - clears on every accepted beat and on entering WAIT;
  - counts in WAIT and RECV;
  - when it reaches TIMEOUT, set error=1, drop buffered words, go to IDLE.
REQ-028 error stays 1 until reset. New frames may still start while error=1.
REQ-029 rd_data_valid is ignored in IDLE, SOF, REQ and DRAIN.
REQ-030 start_frame is ignored while busy=1.
REQ-031 cmd_en and queue_wr_en are never high in the same cycle.
REQ-032 burst_idx is 18 bits wide; addr arithmetic truncates to 21 bits.

Reset
REQ-033 While rst_n=0, the state is IDLE, regardless of the current state (reset may arrive mid-burst).
REQ-034 While rst_n=0, the following are 0: cmd_en, cmd, addr, queue_wr_en, queue_data, busy, error, burst_idx, timeout counter, beat counters.
REQ-035 After reset deasserts, no memory or queue activity occurs until the next qualifying start_frame.

Verification
REQ-036 Single frame (FRAME_WORDS=16, BASE_ADDR=21'h096040, queue_afull=0):
  - stimulus: start_frame; respond to each cmd_en 3 cycles later with 8 consecutive beats 32'h0001_0000 + k;
  - response: 17'h10000, then 16 entries per burst in low/high order;
  - second cmd_en carries addr 21'h096048;
  - busy falls after 33 queue writes.
REQ-037 Backpressure: hold queue_afull=1 for 20 cycles after SOF -> cmd_en stays 0 throughout, then pulses once when queue_afull drops.
REQ-038 Gapped beats: 8 beats with rd_data_valid toggling every other cycle -> same 16 entries; no error.
REQ-039 Timeout (TIMEOUT=64): no rd_data_valid after cmd_en -> error=1 exactly 64 cycles after entering WAIT; state IDLE; no pixel entries written.
REQ-040 start_frame with init_done=0 -> no queue write, no cmd_en.
REQ-041 rst_n pulsed low mid-DRAIN -> all outputs 0 immediately; a subsequent start_frame restarts at BASE_ADDR with a fresh 17'h10000.

Source files
------------

// File: rtl/video_frame_reader.sv
// Reads one video frame from SDRAM in 8-word bursts and streams 16-bit pixels,
// preceded by a start-of-frame marker, into an output queue.
module video_frame_reader #(
  parameter logic [20:0] BASE_ADDR   = 21'h000000,
  parameter int unsigned FRAME_WORDS = 153600,
  parameter int unsigned ADDR_STEP   = 8,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        start_frame,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] addr,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  input  logic        queue_afull,
  output logic        busy,
  output logic        error
);

  localparam int unsigned IDX_W = 18;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [16:0] SOF_MARK = 17'h10000;

  typedef enum logic [2:0] {IDLE, SOF, REQ, WAIT, RECV, DRAIN} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   burst_idx, burst_idx_d;
  logic [2:0]         beat_cnt, beat_cnt_d;
  logic [3:0]         drain_cnt, drain_cnt_d;
  logic [TO_W-1:0]    tcnt, tcnt_d;
  logic [31:0]        word_buf [8];
  logic               beat_we;
  logic               cmd_en_d, queue_wr_en_d, busy_d, error_d;
  logic [20:0]        addr_d;
  logic [16:0]        queue_data_d;
  logic [3:0]         drain_nxt;
  logic [31:0]        drain_word;
  logic               more_bursts;

  assign cmd = 1'b0;

  assign drain_nxt   = drain_cnt + 4'd1;
  assign drain_word  = word_buf[drain_nxt[3:1]];
  assign more_bursts = ((32'(burst_idx) + 32'd1) * 32'd8) < FRAME_WORDS;

  // Outputs are registered from next-state decisions so they line up with the state they belong to.
  always_comb begin
    state_d       = state;
    burst_idx_d   = burst_idx;
    beat_cnt_d    = beat_cnt;
    drain_cnt_d   = drain_cnt;
    tcnt_d        = tcnt;
    beat_we       = 1'b0;
    cmd_en_d      = 1'b0;
    addr_d        = '0;
    queue_wr_en_d = 1'b0;
    queue_data_d  = '0;
    error_d       = error;

    case (state)
      IDLE: begin
        if (start_frame && init_done) begin
          state_d       = SOF;
          burst_idx_d   = '0;
          queue_wr_en_d = 1'b1;
          queue_data_d  = SOF_MARK;
        end
      end
      SOF: state_d = REQ;
      REQ: begin
        if (!queue_afull) begin
          state_d    = WAIT;
          cmd_en_d   = 1'b1;
          addr_d     = BASE_ADDR + 21'(32'(burst_idx) * ADDR_STEP);
          tcnt_d     = '0;
          beat_cnt_d = '0;
        end
      end
      WAIT, RECV: begin
        if (rd_data_valid) begin
          beat_we    = 1'b1;
          tcnt_d     = '0;
          beat_cnt_d = beat_cnt + 3'd1;
          if (beat_cnt == 3'd7) begin
            // word 0 is already buffered, so the first entry can go out with the last beat
            state_d       = DRAIN;
            drain_cnt_d   = '0;
            queue_wr_en_d = 1'b1;
            queue_data_d  = {1'b0, word_buf[0][15:0]};
          end else begin
            state_d = RECV;
          end
        end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt + TO_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd15) begin
          if (more_bursts) begin
            burst_idx_d = burst_idx + 18'd1;
            state_d     = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drain_cnt_d   = drain_nxt;
          queue_wr_en_d = 1'b1;
          queue_data_d  = {1'b0, drain_nxt[0] ? drain_word[31:16] : drain_word[15:0]};
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_idx   <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      tcnt        <= '0;
      cmd_en      <= 1'b0;
      addr        <= '0;
      queue_wr_en <= 1'b0;
      queue_data  <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      burst_idx   <= burst_idx_d;
      beat_cnt    <= beat_cnt_d;
      drain_cnt   <= drain_cnt_d;
      tcnt        <= tcnt_d;
      cmd_en      <= cmd_en_d;
      addr        <= addr_d;
      queue_wr_en <= queue_wr_en_d;
      queue_data  <= queue_data_d;
      busy        <= busy_d;
      error       <= error_d;
    end
  end

  // Burst data buffer; contents are meaningless outside RECV/DRAIN so it needs no reset.
  always_ff @(posedge clk) begin
    if (beat_we) word_buf[beat_cnt] <= rd_data;
  end

endmodule

// File: tb/tb_video_frame_reader.sv
// Directed bench for video_frame_reader: 2-burst frames with a small SDRAM
// responder, backpressure, gapped beats, timeout and mid-burst reset.
module tb_video_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        start_frame = 1'b0;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [31:0] rd_data = '0;
  logic        rd_data_valid = 1'b0;
  logic        queue_wr_en;
  logic [16:0] queue_data;
  logic        queue_afull = 1'b0;
  logic        busy;
  logic        error;

  int errors = 0;
  int checks = 0;
  logic [16:0] cap[$];
  logic [20:0] addr_q[$];
  bit  resp_on = 1'b1;
  bit  gap = 1'b0;
  int  beat_k = 0;

  video_frame_reader #(
    .BASE_ADDR  (21'h096040),
    .FRAME_WORDS(16),
    .ADDR_STEP  (8),
    .TIMEOUT    (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_done    (init_done),
    .start_frame  (start_frame),
    .cmd          (cmd),
    .cmd_en       (cmd_en),
    .addr         (addr),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .queue_wr_en  (queue_wr_en),
    .queue_data   (queue_data),
    .queue_afull  (queue_afull),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Queue writes and command strobes, sampled mid-cycle
  always @(negedge clk) begin
    if (queue_wr_en === 1'b1) cap.push_back(queue_data);
    if (cmd_en === 1'b1) begin
      addr_q.push_back(addr);
      check("cmd_read", 32'(cmd), 32'd0);
      check("cmd_wr_exclusive", 32'(queue_wr_en), 32'd0);
    end
  end

  // SDRAM model: 8 beats of 32'h0001_0000 + k, starting 3 edges after cmd_en
  initial forever begin
    @(negedge clk); #1;
    if (cmd_en === 1'b1 && resp_on) begin
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        #1;
        rd_data = 32'h0001_0000 + 32'(beat_k);
        rd_data_valid = 1'b1;
        beat_k++;
        @(negedge clk);
        if (gap) begin
          #1 rd_data_valid = 1'b0;
          @(negedge clk);
        end
      end
      #1 rd_data_valid = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start_frame = 1'b1;
    @(negedge clk); #1;
    start_frame = 1'b0;
  endtask

  task automatic clear_logs();
    cap.delete();
    addr_q.delete();
    beat_k = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin cyc(1); n++; end
    check({tag, "_idle_in_time"}, 32'(n < 400), 32'd1);
  endtask

  task automatic verify_frame(input string tag);
    logic [16:0] expv;
    check({tag, "_writes"}, 32'(cap.size()), 32'd33);
    check({tag, "_cmds"}, 32'(addr_q.size()), 32'd2);
    if (cap.size() == 33) begin
      check({tag, "_sof"}, 32'(cap[0]), 32'h10000);
      for (int e = 0; e < 32; e++) begin
        expv = (e % 2 == 0) ? 17'(e / 2) : 17'h00001;
        check({tag, "_pixel"}, 32'(cap[e+1]), 32'(expv));
      end
    end
    if (addr_q.size() == 2) begin
      check({tag, "_addr0"}, 32'(addr_q[0]), 32'h096040);
      check({tag, "_addr1"}, 32'(addr_q[1]), 32'h096048);
    end
    check({tag, "_no_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int n;

    // reset state
    cyc(3);
    check("rst_cmd_en", 32'(cmd_en), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_qwe", 32'(queue_wr_en), 32'd0);
    check("rst_qdata", 32'(queue_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // start ignored while init_done=0
    start_pulse();
    cyc(10);
    check("noinit_writes", 32'(cap.size()), 32'd0);
    check("noinit_cmds", 32'(addr_q.size()), 32'd0);
    check("noinit_busy", 32'(busy), 32'd0);

    // single frame, back-to-back beats
    init_done = 1'b1;
    clear_logs();
    start_pulse();
    check("frame_busy", 32'(busy), 32'd1);
    wait_idle("frame");
    verify_frame("frame");

    // gapped beats
    clear_logs();
    gap = 1'b1;
    start_pulse();
    wait_idle("gap");
    verify_frame("gap");
    gap = 1'b0;

    // backpressure holds off the command but not the SOF marker
    clear_logs();
    queue_afull = 1'b1;
    start_pulse();
    cyc(20);
    check("bp_no_cmd", 32'(addr_q.size()), 32'd0);
    check("bp_sof_written", 32'(cap.size()), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    queue_afull = 1'b0;
    cyc(3);
    check("bp_one_cmd", 32'(addr_q.size()), 32'd1);
    wait_idle("bp");
    verify_frame("bp");

    // timeout with no read data
    clear_logs();
    resp_on = 1'b0;
    start_pulse();
    n = 0;
    while (addr_q.size() == 0 && n < 20) begin cyc(1); n++; end
    check("to_cmd_seen", 32'(addr_q.size()), 32'd1);
    n = 0;
    while (error !== 1'b1 && n < 200) begin cyc(1); n++; end
    check("to_latency", 32'(n), 32'd64);
    check("to_error", 32'(error), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    check("to_only_sof", 32'(cap.size()), 32'd1);
    resp_on = 1'b1;

    // frame restarts while error is sticky; reset lands mid-DRAIN
    clear_logs();
    start_pulse();
    n = 0;
    while (cap.size() < 6 && n < 100) begin cyc(1); n++; end
    check("rstmid_in_drain", 32'(cap.size()), 32'd6);
    check("rstmid_error_sticky", 32'(error), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_cmd_en", 32'(cmd_en), 32'd0);
    check("rstmid_addr", 32'(addr), 32'd0);
    check("rstmid_qwe", 32'(queue_wr_en), 32'd0);
    check("rstmid_qdata", 32'(queue_data), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_error", 32'(error), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    clear_logs();
    cyc(5);
    check("postrst_quiet_wr", 32'(cap.size()), 32'd0);
    check("postrst_quiet_cmd", 32'(addr_q.size()), 32'd0);
    start_pulse();
    wait_idle("restart");
    verify_frame("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
